// File: rtl/pc_pkg.sv
// pc_pkg: shared redirect-source encoding and RAS sizing helper for the PC unit.
package pc_pkg;
  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_JUMP   = 3'd1,
    SRC_CALL   = 3'd2,
    SRC_RET    = 3'd3,
    SRC_BRANCH = 3'd4,
    SRC_TRAP   = 3'd5
  } redirect_src_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; overflowing push overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = cnt_w(RAS_DEPTH);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   tp;
  logic [CW-1:0]   cnt;
  assign tp    = wp - PW'(1);
  assign top   = mem[tp];
  assign empty = cnt == '0;
  assign full  = cnt == CW'(RAS_DEPTH);
  always_ff @(posedge clk)
    if (!rst) begin
      wp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wp  <= '0;
      cnt <= '0;
    end else if (pop && !push) begin
      wp  <= tp;
      cnt <= cnt - CW'(1);
    end else if (push && !pop) begin
      wp       <= wp + PW'(1);
      cnt      <= full ? cnt : cnt + CW'(1);
      overflow <= overflow | full;
    end
  // push with pop replaces the current top in place
  always_ff @(posedge clk)
    if (rst && !flush && push) mem[pop ? tp : wp] <= push_data;
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: IF-stage program counter with prioritised redirects and return-address stack.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              STEP      = 1,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_PC   = XLEN'(32'h0000_0040),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            trap,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic            redirect,
  output redirect_src_e   redirect_src,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ret_miss
);
  logic [XLEN-1:0] seq, nxt, top;
  logic            take_ret, ret_hit, take_jump, push, pop, flush;
  redirect_src_e   src;
  always_comb begin
    seq       = pc + XLEN'(STEP);
    take_ret  = !trap && !branch_taken && ret;
    ret_hit   = take_ret && !ras_empty;
    take_jump = !trap && !branch_taken && !ret && jump;
    push      = pc_write && call && (take_jump || ret_hit);
    pop       = pc_write && ret_hit;
    flush     = pc_write && trap;
    src       = trap ? SRC_TRAP : branch_taken ? SRC_BRANCH : ret_hit ? SRC_RET :
                take_jump ? (call ? SRC_CALL : SRC_JUMP) : SRC_SEQ;
    nxt       = trap ? TRAP_PC : branch_taken ? branch_target : ret_hit ? top :
                take_jump ? jump_target : seq;
  end
  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .push_data(seq),
    .top      (top),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow)
  );
  // a stall keeps redirect_src as the source of the last real update
  always_ff @(posedge clk)
    if (!rst) begin
      pc           <= RESET_PC;
      redirect     <= 1'b0;
      redirect_src <= SRC_SEQ;
      ret_miss     <= 1'b0;
    end else if (pc_write) begin
      pc           <= nxt;
      redirect     <= src != SRC_SEQ;
      redirect_src <= src;
      ret_miss     <= take_ret && ras_empty;
    end else begin
      redirect <= 1'b0;
      ret_miss <= 1'b0;
    end
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed plus random stimulus scored against a queue-based reference model.
module tb_pc_unit_ras;
  localparam int DEPTH = 4;
  localparam logic [7:0] TRAPV = 8'h40;
  typedef struct packed {
    logic [7:0] pc;
    logic       redir;
    logic [2:0] src;
    logic       emp, ful, ovf, miss;
  } exp_t;
  logic clk = 0, rst = 0, pc_write = 0, trap = 0, branch_taken = 0, jump = 0, call = 0, ret = 0;
  logic [7:0] branch_target = 0, jump_target = 0, pc;
  logic redirect, ras_empty, ras_full, ras_overflow, ret_miss;
  pc_pkg::redirect_src_e redirect_src;
  int errors = 0, checks = 0;
  exp_t q[$];
  logic [7:0] m_pc = 0;
  logic [7:0] m_stk[$];
  logic m_ovf = 0, m_redir = 0, m_miss = 0;
  logic [2:0] m_src = 0;
  bit done = 0;
  pc_unit_ras #(.XLEN(8), .STEP(1), .RESET_PC(8'h00), .TRAP_PC(TRAPV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .trap(trap), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target), .call(call),
    .ret(ret), .pc(pc), .redirect(redirect), .redirect_src(redirect_src), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ret_miss(ret_miss)
  );
  always #5 clk = ~clk;
  function automatic void m_push(input logic [7:0] v);
    if (m_stk.size() == DEPTH) begin
      void'(m_stk.pop_front());
      m_ovf = 1;
    end
    m_stk.push_back(v);
  endfunction
  // reference model: next state from the redirect rules, stack kept as a plain queue
  function automatic void model();
    logic [7:0] s;
    s = m_pc + 8'd1;
    m_miss = 0;
    if (!rst) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_redir = 0; m_src = 0;
      return;
    end
    if (!pc_write) begin
      m_redir = 0;
      return;
    end
    if (trap) begin m_pc = TRAPV; m_stk.delete(); m_src = 5; end
    else if (branch_taken) begin m_pc = branch_target; m_src = 4; end
    else if (ret) begin
      if (m_stk.size() > 0) begin
        m_pc = m_stk.pop_back();
        if (call) m_push(s);
        m_src = 3;
      end else begin m_pc = s; m_src = 0; m_miss = 1; end
    end else if (jump) begin
      if (call) m_push(s);
      m_src = call ? 3'd2 : 3'd1;
      m_pc = jump_target;
    end else begin m_pc = s; m_src = 0; end
    m_redir = m_src != 0;
  endfunction
  task automatic drive(input bit r, input bit pw, input bit tr, input bit br, input logic [7:0] bt,
                       input bit j, input logic [7:0] jt, input bit c, input bit rt);
    @(negedge clk);
    rst = r; pc_write = pw; trap = tr; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; call = c; ret = rt;
    model();
    q.push_back('{m_pc, m_redir, m_src, m_stk.size() == 0, m_stk.size() == DEPTH, m_ovf, m_miss});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", 32'(pc), 32'(e.pc));
        chk("redirect", 32'(redirect), 32'(e.redir));
        chk("redirect_src", 32'(redirect_src), 32'(e.src));
        chk("ras_empty", 32'(ras_empty), 32'(e.emp));
        chk("ras_full", 32'(ras_full), 32'(e.ful));
        chk("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
        chk("ret_miss", 32'(ret_miss), 32'(e.miss));
      end
    end
  end
  initial begin : stim
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    drive(1, 1, 0, 0, 0, 1, 8'h20, 1, 0);
    idle(1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1, 8'h30, 1, 0);
    drive(1, 1, 0, 0, 0, 1, 8'h38, 1, 0);
    drive(1, 1, 1, 1, 8'h80, 1, 8'h90, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 1, 8'(8'h50 + 8'(i * 16)), 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    drive(1, 0, 0, 0, 0, 1, 8'hA0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 8'hA0, 1, 0);
    drive(1, 1, 0, 0, 0, 1, 8'hA0, 1, 0);
    drive(1, 1, 0, 1, 8'hFF, 0, 0, 0, 0);
    idle(1);
    drive(1, 1, 0, 1, 8'h3F, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 8'h70, 1, 0);
    drive(1, 1, 0, 1, 8'h10, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 8'h22, 1, 1);
    idle(2);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(99) != 0, $urandom_range(99) < 85, $urandom_range(99) < 4,
            $urandom_range(99) < 10, 8'($urandom), $urandom_range(99) < 30, 8'($urandom),
            $urandom_range(1) == 1, $urandom_range(99) < 25);
    idle(1);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
